multi_cycle_controller: RTL and testbench

- Moore FSM sequencer for the multi-cycle RV32I datapath (lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal).
- Consumes the decoded instruction fields and ALU zero flag from the datapath, and returns every per-cycle enable and mux select the datapath needs.
- Waits on a memory ready handshake for every shared instruction/data memory access.

---
 rtl/multi_cycle_controller_pkg.sv | 59 +++++
 rtl/multi_cycle_controller_if.sv | 34 +++
 rtl/multi_cycle_controller_alu_decoder.sv | 34 +++
 rtl/multi_cycle_controller.sv | 157 +++++++++++++++
 tb/tb_multi_cycle_controller.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_controller_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller.
// Holds the state encoding, mux-select enums, ALU op codes and the supported opcodes.
package pa_riscv;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECUTER = 4'd6,
    ST_EXECUTEI = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BEQ      = 4'd9,
    ST_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_REG   = 2'b10
  } srca_t;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  function automatic logic fn_is_supported(input logic [6:0] i_op);
    logic r_ok;
    case (i_op)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: r_ok = 1'b1;
      default:                                          r_ok = 1'b0;
    endcase
    return r_ok;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle: decoded fields and handshakes in, enables and selects out.
// The datapath side is the master, the controller the slave.
interface mcc_if;
  logic [6:0] i_operand;
  logic [2:0] i_funct3;
  logic       i_funct7bit5;
  logic       i_zeroFlag;
  logic       i_memReady;
  logic       o_pcWriteEn;
  logic       o_adrSel;
  logic       o_memWriteEn;
  logic       o_instructionRegWrite;
  logic       o_regWriteEn;
  logic [1:0] o_resultSel;
  logic [1:0] o_aluInputASel;
  logic [1:0] o_aluInputBSel;
  logic [3:0] o_aluLogicOperation;
  logic       o_illegalInstr;
  logic [3:0] o_state;

  modport master (
    output i_operand, i_funct3, i_funct7bit5, i_zeroFlag, i_memReady,
    input  o_pcWriteEn, o_adrSel, o_memWriteEn, o_instructionRegWrite, o_regWriteEn,
           o_resultSel, o_aluInputASel, o_aluInputBSel, o_aluLogicOperation,
           o_illegalInstr, o_state
  );

  modport slave (
    input  i_operand, i_funct3, i_funct7bit5, i_zeroFlag, i_memReady,
    output o_pcWriteEn, o_adrSel, o_memWriteEn, o_instructionRegWrite, o_regWriteEn,
           o_resultSel, o_aluInputASel, o_aluInputBSel, o_aluLogicOperation,
           o_illegalInstr, o_state
  );
endinterface

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU operation decode for R-type and I-type instructions.
// Only R-type honours funct7bit5, so addi with imm[10]=1 still adds.
import pa_riscv::*;

module alu_decoder (
  input  logic [6:0] i_operand,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  output logic [3:0] o_aluLogicOperation
);

  logic w_isRtype;

  assign w_isRtype = (i_operand == OP_RTYPE);

  // funct3 to ALU operation; unsupported funct3 quietly falls back to add
  always_comb begin
    o_aluLogicOperation = ALU_ADD;
    case (i_funct3)
      3'b000: begin
        if (w_isRtype && i_funct7bit5) begin
          o_aluLogicOperation = ALU_SUB;
        end else begin
          o_aluLogicOperation = ALU_ADD;
        end
      end
      3'b010:  o_aluLogicOperation = ALU_SLT;
      3'b110:  o_aluLogicOperation = ALU_OR;
      3'b111:  o_aluLogicOperation = ALU_AND;
      default: o_aluLogicOperation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore sequencer for the multi-cycle RV32I datapath; outputs decode from state, with
// memReady/zeroFlag qualifying only the enables that depend on them.
import pa_riscv::*;

module multi_cycle_controller (
  input  logic  i_clk,
  input  logic  i_srst_n,
  mcc_if.slave  if_bus
);

  state_t     r_state;
  logic [3:0] w_aluOp;
  logic       w_pcWriteEn;
  logic       w_adrSel;
  logic       w_memWriteEn;
  logic       w_instructionRegWrite;
  logic       w_regWriteEn;
  result_t    w_resultSel;
  srca_t      w_srcA;
  srcb_t      w_srcB;
  logic [3:0] w_aluLogicOperation;
  logic       w_illegalInstr;

  alu_decoder u_alu_decoder (
    .i_operand           (if_bus.i_operand),
    .i_funct3            (if_bus.i_funct3),
    .i_funct7bit5        (if_bus.i_funct7bit5),
    .o_aluLogicOperation (w_aluOp)
  );

  // State register and transitions; reset wins even during a memory wait
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      r_state <= ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (if_bus.i_memReady) r_state <= ST_DECODE;
          else                   r_state <= ST_FETCH;
        end
        ST_DECODE: begin
          case (if_bus.i_operand)
            OP_LW, OP_SW: r_state <= ST_MEMADR;
            OP_RTYPE:     r_state <= ST_EXECUTER;
            OP_ITYPE:     r_state <= ST_EXECUTEI;
            OP_BEQ:       r_state <= ST_BEQ;
            OP_JAL:       r_state <= ST_JAL;
            default:      r_state <= ST_FETCH;
          endcase
        end
        ST_MEMADR: begin
          if (if_bus.i_operand == OP_SW) r_state <= ST_MEMWRITE;
          else                           r_state <= ST_MEMREAD;
        end
        ST_MEMREAD: begin
          if (if_bus.i_memReady) r_state <= ST_MEMWB;
          else                   r_state <= ST_MEMREAD;
        end
        ST_MEMWRITE: begin
          if (if_bus.i_memReady) r_state <= ST_FETCH;
          else                   r_state <= ST_MEMWRITE;
        end
        ST_EXECUTER, ST_EXECUTEI: r_state <= ST_ALUWB;
        ST_JAL:                   r_state <= ST_ALUWB;
        default:                  r_state <= ST_FETCH;
      endcase
    end
  end

  // Per-state enables and selects; reset masks enables and parks selects at FETCH values
  always_comb begin
    w_pcWriteEn           = 1'b0;
    w_adrSel              = 1'b0;
    w_memWriteEn          = 1'b0;
    w_instructionRegWrite = 1'b0;
    w_regWriteEn          = 1'b0;
    w_resultSel           = RES_ALUOUT;
    w_srcA                = SRCA_PC;
    w_srcB                = SRCB_REG;
    w_aluLogicOperation   = ALU_ADD;
    w_illegalInstr        = 1'b0;
    if (!i_srst_n) begin
      w_srcB      = SRCB_FOUR;
      w_resultSel = RES_ALURESULT;
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_srcB                = SRCB_FOUR;
          w_resultSel           = RES_ALURESULT;
          w_instructionRegWrite = if_bus.i_memReady;
          w_pcWriteEn           = if_bus.i_memReady;
        end
        ST_DECODE: begin
          w_srcA         = SRCA_OLDPC;
          w_srcB         = SRCB_IMM;
          w_illegalInstr = !fn_is_supported(if_bus.i_operand);
        end
        ST_MEMADR: begin
          w_srcA = SRCA_REG;
          w_srcB = SRCB_IMM;
        end
        ST_MEMREAD: begin
          w_adrSel = 1'b1;
        end
        ST_MEMWB: begin
          w_resultSel  = RES_DATA;
          w_regWriteEn = 1'b1;
        end
        ST_MEMWRITE: begin
          w_adrSel     = 1'b1;
          w_memWriteEn = 1'b1;
        end
        ST_EXECUTER: begin
          w_srcA              = SRCA_REG;
          w_srcB              = SRCB_REG;
          w_aluLogicOperation = w_aluOp;
        end
        ST_EXECUTEI: begin
          w_srcA              = SRCA_REG;
          w_srcB              = SRCB_IMM;
          w_aluLogicOperation = w_aluOp;
        end
        ST_ALUWB: begin
          w_regWriteEn = 1'b1;
        end
        ST_BEQ: begin
          w_srcA              = SRCA_REG;
          w_srcB              = SRCB_REG;
          w_aluLogicOperation = ALU_SUB;
          w_pcWriteEn         = if_bus.i_zeroFlag;
        end
        ST_JAL: begin
          w_srcA      = SRCA_OLDPC;
          w_srcB      = SRCB_FOUR;
          w_pcWriteEn = 1'b1;
        end
        default: begin
          w_srcB      = SRCB_FOUR;
          w_resultSel = RES_ALURESULT;
        end
      endcase
    end
  end

  assign if_bus.o_pcWriteEn           = w_pcWriteEn;
  assign if_bus.o_adrSel              = w_adrSel;
  assign if_bus.o_memWriteEn          = w_memWriteEn;
  assign if_bus.o_instructionRegWrite = w_instructionRegWrite;
  assign if_bus.o_regWriteEn          = w_regWriteEn;
  assign if_bus.o_resultSel           = w_resultSel;
  assign if_bus.o_aluInputASel        = w_srcA;
  assign if_bus.o_aluInputBSel        = w_srcB;
  assign if_bus.o_aluLogicOperation   = w_aluLogicOperation;
  assign if_bus.o_illegalInstr        = w_illegalInstr;
  assign if_bus.o_state               = r_state;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: the driver walks each instruction through its expected cycle trace,
// pushing one expected output vector per cycle; a negedge monitor pops and compares.
import pa_riscv::*;

module tb_multi_cycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       pcWe;
    logic       adrSel;
    logic       memWe;
    logic       irw;
    logic       regWe;
    logic [1:0] resSel;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [3:0] aluOp;
    logic       illegal;
  } exp_t;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  logic done = 1'b0;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    reported = 1'b0;

  mcc_if u_if ();

  multi_cycle_controller dut (
    .i_clk    (clk),
    .i_srst_n (srst_n),
    .if_bus   (u_if)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input state_t s);
    exp_t e;
    e = '0;
    e.state = s;
    e.resSel = RES_ALUOUT;
    e.srcA = SRCA_PC;
    e.srcB = SRCB_REG;
    e.aluOp = ALU_ADD;
    return e;
  endfunction

  function automatic logic [3:0] model_op(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    if (f3 == 3'b010) return ALU_SLT;
    if (f3 == 3'b110) return ALU_OR;
    if (f3 == 3'b111) return ALU_AND;
    if (f3 == 3'b000 && instr[6:0] == OP_RTYPE && instr[30]) return ALU_SUB;
    return ALU_ADD;
  endfunction

  function automatic bit model_legal(input logic [6:0] op);
    logic [6:0] legal [6];
    legal = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL};
    foreach (legal[k]) if (legal[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // one cycle: drive qualifiers, register what the DUT must show, advance
  task automatic cyc(input exp_t e, input string nm, input logic rdy, input logic zf);
    u_if.i_memReady = rdy;
    u_if.i_zeroFlag = zf;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input logic zf);
    exp_t e;
    logic [6:0] op;
    op = instr[6:0];
    u_if.i_operand = op;
    u_if.i_funct3 = instr[14:12];
    u_if.i_funct7bit5 = instr[30];
    for (int w = 0; w <= fw; w++) begin
      e = mk(ST_FETCH);
      e.srcB = SRCB_FOUR;
      e.resSel = RES_ALURESULT;
      e.irw = (w == fw);
      e.pcWe = (w == fw);
      cyc(e, "fetch", (w == fw), 1'($urandom_range(0, 1)));
    end
    e = mk(ST_DECODE);
    e.srcA = SRCA_OLDPC;
    e.srcB = SRCB_IMM;
    e.illegal = !model_legal(op);
    cyc(e, "decode", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    if (!model_legal(op)) return;
    if (op == OP_LW || op == OP_SW) begin
      e = mk(ST_MEMADR);
      e.srcA = SRCA_REG;
      e.srcB = SRCB_IMM;
      cyc(e, "memadr", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int w = 0; w <= mw; w++) begin
        e = mk(op == OP_LW ? ST_MEMREAD : ST_MEMWRITE);
        e.adrSel = 1'b1;
        e.memWe = (op == OP_SW);
        cyc(e, op == OP_LW ? "memread" : "memwrite", (w == mw), 1'($urandom_range(0, 1)));
      end
      if (op == OP_LW) begin
        e = mk(ST_MEMWB);
        e.resSel = RES_DATA;
        e.regWe = 1'b1;
        cyc(e, "memwb", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end else if (op == OP_BEQ) begin
      e = mk(ST_BEQ);
      e.srcA = SRCA_REG;
      e.srcB = SRCB_REG;
      e.aluOp = ALU_SUB;
      e.pcWe = zf;
      cyc(e, "beq", 1'($urandom_range(0, 1)), zf);
    end else begin
      if (op == OP_JAL) begin
        e = mk(ST_JAL);
        e.srcA = SRCA_OLDPC;
        e.srcB = SRCB_FOUR;
        e.pcWe = 1'b1;
        cyc(e, "jal", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        e = mk(op == OP_RTYPE ? ST_EXECUTER : ST_EXECUTEI);
        e.srcA = SRCA_REG;
        e.srcB = (op == OP_RTYPE) ? SRCB_REG : SRCB_IMM;
        e.aluOp = model_op(instr);
        cyc(e, "execute", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      e = mk(ST_ALUWB);
      e.regWe = 1'b1;
      cyc(e, "aluwb", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic reset_cycle(input state_t s);
    exp_t e;
    srst_n = 1'b0;
    e = mk(s);
    e.srcB = SRCB_FOUR;
    e.resSel = RES_ALURESULT;
    cyc(e, "reset", 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] instr;
    logic [6:0]  op;
    exp_t        e;
    int          cls;
    u_if.i_operand = 7'd0;
    u_if.i_funct3 = 3'd0;
    u_if.i_funct7bit5 = 1'b0;
    u_if.i_zeroFlag = 1'b0;
    u_if.i_memReady = 1'b0;
    @(posedge clk);
    #1;
    reset_cycle(ST_FETCH);
    srst_n = 1'b1;

    // sw parked in MEMWRITE waiting on memory, then reset for 3 cycles
    u_if.i_operand = OP_SW;
    u_if.i_funct3 = 3'b010;
    e = mk(ST_FETCH); e.srcB = SRCB_FOUR; e.resSel = RES_ALURESULT; e.irw = 1'b1; e.pcWe = 1'b1;
    cyc(e, "rst_fetch", 1'b1, 1'b0);
    e = mk(ST_DECODE); e.srcA = SRCA_OLDPC; e.srcB = SRCB_IMM;
    cyc(e, "rst_decode", 1'b0, 1'b0);
    e = mk(ST_MEMADR); e.srcA = SRCA_REG; e.srcB = SRCB_IMM;
    cyc(e, "rst_memadr", 1'b0, 1'b0);
    e = mk(ST_MEMWRITE); e.adrSel = 1'b1; e.memWe = 1'b1;
    cyc(e, "rst_memwrite", 1'b0, 1'b0);
    reset_cycle(ST_MEMWRITE);
    reset_cycle(ST_FETCH);
    reset_cycle(ST_FETCH);
    srst_n = 1'b1;
    #1;
    if (u_if.o_state !== 4'(ST_FETCH)) begin
      n_err++;
      $display("FAIL post_reset: state=%0d expected FETCH", u_if.o_state);
    end
    if (u_if.o_memWriteEn !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: memWriteEn still asserted");
    end

    run_instr(32'h002081B3, 0, 0, 1'b0);
    run_instr(32'h402081B3, 0, 0, 1'b0);
    run_instr(32'h40008093, 0, 0, 1'b0);
    run_instr(32'h0000A183, 2, 3, 1'b0);
    run_instr(32'h00208463, 0, 0, 1'b1);
    run_instr(32'h00208463, 0, 0, 1'b0);
    run_instr(32'h008000EF, 0, 0, 1'b0);
    run_instr(32'h0000007F, 0, 0, 1'b0);
    if (u_if.o_state !== 4'(ST_FETCH)) begin
      n_err++;
      $display("FAIL illegal: state=%0d expected FETCH after illegal opcode", u_if.o_state);
    end

    for (int i = 0; i < 80; i++) begin
      instr = $urandom;
      cls = $urandom_range(0, 6);
      case (cls)
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_RTYPE;
        3: op = OP_ITYPE;
        4: op = OP_BEQ;
        5: op = OP_JAL;
        default: begin
          op = 7'($urandom_range(0, 127));
          while (model_legal(op)) op = 7'($urandom_range(0, 127));
        end
      endcase
      instr[6:0] = op;
      run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    done = 1'b1;
    repeat (200) @(posedge clk);
    $display("FAIL timeout: monitor never drained the scoreboard");
    $fatal(1);
  end

  // monitor: one expected vector per cycle, checked mid-cycle
  always @(negedge clk) begin
    exp_t  act;
    exp_t  want;
    string nm;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm = name_q.pop_front();
      act.state   = u_if.o_state;
      act.pcWe    = u_if.o_pcWriteEn;
      act.adrSel  = u_if.o_adrSel;
      act.memWe   = u_if.o_memWriteEn;
      act.irw     = u_if.o_instructionRegWrite;
      act.regWe   = u_if.o_regWriteEn;
      act.resSel  = u_if.o_resultSel;
      act.srcA    = u_if.o_aluInputASel;
      act.srcB    = u_if.o_aluInputBSel;
      act.aluOp   = u_if.o_aluLogicOperation;
      act.illegal = u_if.o_illegalInstr;
      n_vec++;
      if (act !== want) begin
        n_err++;
        $display("FAIL %s @%0t: got %05h (st=%0d) expected %05h (st=%0d)",
                 nm, $time, act, act.state, want, want.state);
      end
    end else if (done && !reported) begin
      reported = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      if (n_err == 0 && n_vec > 0) begin
        $display("PASS");
      end else begin
        $display("FAIL");
      end
      $finish;
    end
  end

endmodule
